imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit instruction words and writes them to consecutive word addresses from 0.
- Holds the CPU in stall while loading, so instruction storage can be filled at runtime instead of by a static initial block.
- Sits between the host/debug byte source and the instruction memory write port.

Parameters:
ADDR_W, 12, width of the word address driven to instruction memory
DEPTH, 128, number of instruction words in memory; loads are clamped to this
BIG_ENDIAN, 0, 0: first byte of a word goes to bits [7:0]; 1: first byte goes to bits [31:24]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE
word_count  input  ADDR_W  number of words to load; latched on accepted start
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid this cycle
byte_ready  output  1  loader accepts a byte this cycle (transfer = valid & ready)
mem_we  output  1  instruction memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_W  word address for the write
mem_wdata  output  32  assembled instruction word
busy  output  1  load in progress
done  output  1  load complete; level, held until the next accepted start or reset
cpu_stall  output  1  equals busy; freezes PC/fetch while memory is rewritten
overflow_err  output  1  set when latched word_count > DEPTH; cleared on next accepted start or reset

Behaviour:
- Reset (synchronous, any state, including mid-load): state=IDLE. byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_stall=0, overflow_err=0. Byte lane counter and word counter are 0. A partially assembled word is discarded.
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE, start=1:
  - Latch target = min(word_count, DEPTH); overflow_err = (word_count > DEPTH).
  - Clear done, word index and lane counter.
  - If target==0, go to DONE (done=1 next cycle, busy never asserts).
  - Otherwise go to RECV; busy=1 next cycle.
- IDLE/DONE, start=0: hold.
- RECV:
  - byte_ready=1.
  - On each transfer, place the byte in lane = lane counter, or 3 - lane counter if BIG_ENDIAN, and increment the lane counter.
  - On the transfer that fills lane 3, go to WRITE; the lane counter wraps to 0.
  - byte_valid=0 leaves all state unchanged.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - Next cycle: word index += 1.
  - If the new index == target, go to DONE (busy=0, done=1 in that same next cycle); else go to RECV.
- Latency: 4th byte transferred in cycle N -> mem_we high in cycle N+1 -> byte_ready high again in N+2. Peak throughput is 1 word per 5 cycles.
- Outputs are registered. mem_we is never high outside WRITE. mem_addr/mem_wdata hold their last values when mem_we=0.
- start while busy (RECV/WRITE): ignored; word_count changes are ignored.
- Excess bytes after the final word: byte_ready=0 in DONE, so they are not consumed.
- Address never exceeds DEPTH-1; no wrap-around is possible because target is clamped.
- cpu_stall is a combinational copy of busy.

Test Plan:
- Load 3 words, bytes 00 00 00 8D, 01 00 41 8D, 20 10 01 00 (BIG_ENDIAN=0), valid every cycle -> mem_we pulses at addr 0,1,2 with data 8D000000, 8D410001, 00011020; done=1 and busy=0 the cycle after the third write; exactly 3 mem_we pulses.
- Same stream with BIG_ENDIAN=1, word 0 bytes 8D 40 00 00 -> mem_wdata=8D400000 at addr 0.
- byte_valid toggling 1/0 with random gaps -> identical writes to the first test; byte_ready=0 during WRITE; no byte lost or duplicated.
- word_count=0 -> done=1 one cycle after start, busy and mem_we never assert. word_count=200 (DEPTH=128) -> overflow_err=1, exactly 128 writes at addr 0..127, then done.
- rst asserted after 6 bytes of a 4-word load -> next cycle all outputs 0, state IDLE. A new start with word_count=1 and 4 bytes writes addr 0 with only the new bytes.
- start pulse during RECV with word_count=1 while loading 2 words -> ignored; 2 writes complete, then done.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. A program image arrives as a byte
//   stream over a valid/ready handshake. The bytes are packed into 32-bit words
//   and written to consecutive word addresses starting at 0. The CPU is held in
//   stall for the whole load.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   start        : one-cycle load request, honoured only in IDLE/DONE
//   word_count   : number of words to load, latched on an accepted start
//   byte_in      : stream data byte
//   byte_valid   : byte_in valid this cycle
//   byte_ready   : loader accepts a byte this cycle
//   mem_we       : one-cycle write strobe per assembled word
//   mem_addr     : word address of the write
//   mem_wdata    : assembled instruction word
//   busy         : load in progress
//   done         : load complete, held until the next accepted start or reset
//   cpu_stall    : copy of busy, freezes fetch while memory is rewritten
//   overflow_err : requested word_count exceeded DEPTH (load was clamped)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 128,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_stall,
  output logic              overflow_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // One extra bit so word_count can be compared against DEPTH without truncation.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] target_q;
  logic [31:0]       word_q;
  logic              byte_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              overflow_err_q;

  logic              xfer_d;
  logic              over_d;
  logic [ADDR_W-1:0] target_d;
  logic [ADDR_W-1:0] idx_d;
  logic [31:0]       word_d;

  // Byte lane that the n-th byte of a word lands in.
  function automatic logic [1:0] lane_sel(input logic [1:0] cnt);
    if (BIG_ENDIAN) begin
      return 2'd3 - cnt;
    end else begin
      return cnt;
    end
  endfunction

  // Replace one byte lane of a word.
  function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Next-state helpers: handshake, length clamp, word index step, merged word.
  always_comb begin
    xfer_d   = byte_valid & byte_ready_q;
    over_d   = ({1'b0, word_count} > DEPTH_EXT);
    if (over_d) begin
      target_d = DEPTH_EXT[ADDR_W-1:0];
    end else begin
      target_d = word_count;
    end
    idx_d    = idx_q + ADDR_W'(1);
    // Includes the byte being transferred now, so the write data is complete
    // on the same edge that moves the FSM into WRITE.
    word_d   = insert_byte(word_q, lane_sel(lane_q), byte_in);
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      lane_q         <= 2'd0;
      idx_q          <= {ADDR_W{1'b0}};
      target_q       <= {ADDR_W{1'b0}};
      word_q         <= 32'd0;
      byte_ready_q   <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= {ADDR_W{1'b0}};
      mem_wdata_q    <= 32'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            target_q       <= target_d;
            overflow_err_q <= over_d;
            idx_q          <= {ADDR_W{1'b0}};
            lane_q         <= 2'd0;
            word_q         <= 32'd0;
            if (target_d == {ADDR_W{1'b0}}) begin
              // Empty load completes immediately; busy never rises.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_RECV;
              done_q       <= 1'b0;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (xfer_d) begin
            word_q <= word_d;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= idx_q;
              mem_wdata_q  <= word_d;
            end
          end
        end
        S_WRITE: begin
          idx_q <= idx_d;
          if (idx_d == target_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q      <= S_RECV;
            byte_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cpu_stall    = busy_q;
  assign overflow_err = overflow_err_q;

endmodule
